// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative Baugh-Wooley multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row counter must also hold WIDTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Baugh-Wooley correction ones at bit WIDTH and bit 2*WIDTH-1.
  function automatic logic [63:0] bw_const(input int unsigned width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/seq_bw_mult_pp_row.sv
// One partial-product row; in signed mode the sign-related bits are inverted.
module bw_pp_row
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_bit_i,
  input  logic             is_signed_i,
  input  logic             is_last_row_i,
  output logic [WIDTH-1:0] pp_o
);

  localparam logic [WIDTH-1:0] MSB_MASK  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LOW_MASK  = ~MSB_MASK;

  logic [WIDTH-1:0] and_row;
  logic [WIDTH-1:0] inv_mask;

  assign and_row = a_i & {WIDTH{b_bit_i}};

  // Last row complements the low bits, other rows complement only the MSB.
  always_comb begin
    inv_mask = '0;
    if (is_signed_i) begin
      inv_mask = is_last_row_i ? LOW_MASK : MSB_MASK;
    end
  end

  assign pp_o = and_row ^ inv_mask;

endmodule

// File: rtl/seq_bw_mult.sv
// Iterative multiplier: one Baugh-Wooley row per clock into a 2*WIDTH accumulator.
module seq_bw_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [PW-1:0]    BW_INIT  = PW'(bw_const(WIDTH));
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [CNT_W-1:0] row_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] pp_row;
  logic             last_row;
  logic             accept;

  assign b_shift  = b_q >> row_q;
  assign last_row = (row_q == LAST_ROW);

  bw_pp_row #(
    .WIDTH(WIDTH)
  ) u_pp_row (
    .a_i          (a_q),
    .b_bit_i      (b_shift[0]),
    .is_signed_i  (signed_q),
    .is_last_row_i(last_row),
    .pp_o         (pp_row)
  );

  assign acc_d = acc_q + (PW'(pp_row) << row_q);

  // DONE lets a new operand pair in on the same edge the result is taken.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      acc_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= is_signed;
            acc_q    <= is_signed ? BW_INIT : '0;
            row_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          row_q <= row_q + CNT_W'(1);
          if (last_row) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q      <= a;
              b_q      <= b;
              signed_q <= is_signed;
              acc_q    <= is_signed ? BW_INIT : '0;
              row_q    <= '0;
              state_q  <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_bw_mult.sv
// Scoreboard bench: directed WIDTH=5 cases plus a randomized WIDTH=8 sweep.
module tb_seq_bw_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=5 instance
  logic       rst5_n, in_valid5, in_ready5, s5, out_valid5, out_ready5;
  logic [4:0] a5, b5;
  logic [9:0] product5;
  logic [9:0] exp5_q[$];

  // WIDTH=8 instance
  logic        rst8_n, in_valid8, in_ready8, s8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic [15:0] exp8_q[$];
  logic        pv8, pr8;
  bit          drive_ready8;

  seq_bw_mult #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .is_signed(s5), .out_valid(out_valid5),
    .out_ready(out_ready5), .product(product5)
  );

  seq_bw_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8)
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Integer product of the operands as numbers, reduced mod 2^16 (caller truncates further).
  function automatic logic [15:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn, input int unsigned w);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (sgn && (((a >> (w - 1)) & 32'd1) != 32'd0)) x = x - (longint'(1) << w);
    if (sgn && (((b >> (w - 1)) & 32'd1) != 32'd0)) y = y - (longint'(1) << w);
    p = x * y;
    return 16'(p);
  endfunction

  // Monitors: compare on every output handshake; any output with an empty queue is a failure.
  always @(negedge clk) begin
    if (rst5_n && out_valid5 && out_ready5) begin
      if (exp5_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w5_unexpected_output got=%0h expected=none at %0t", product5, $time);
      end else begin
        chk("w5_product", 32'(product5), 32'(exp5_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst8_n) begin
      if (pv8 && !pr8) chk("w8_valid_held", 32'(out_valid8), 32'd1);
      if (out_valid8) begin
        if (exp8_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL w8_unexpected_output got=%0h expected=none at %0t", product8, $time);
        end else begin
          chk("w8_product", 32'(product8), 32'(exp8_q[0]));
          if (out_ready8) void'(exp8_q.pop_front());
        end
      end
    end
    pv8 = out_valid8;
    pr8 = out_ready8;
  end

  // Random back-pressure on the WIDTH=8 consumer side.
  initial begin
    out_ready8 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready8 = drive_ready8 ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic accept5(input logic [4:0] a, input logic [4:0] b, input bit s,
                         input bit push, input logic [9:0] e);
    int n = 0;
    in_valid5 = 1'b1; a5 = a; b5 = b; s5 = s;
    forever begin
      @(negedge clk);
      if (in_ready5) break;
      if (n >= 50) begin
        chk("w5_accept_timeout", 32'(in_ready5), 32'd1);
        break;
      end
      @(posedge clk); #1; n++;
    end
    if (push) exp5_q.push_back(e);
    @(posedge clk); #1;
    in_valid5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom); s5 = 1'($urandom);
  endtask

  task automatic wait_valid5(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid5) break;
      if (n >= 40) begin
        chk("w5_valid_timeout", 32'(out_valid5), 32'd1);
        break;
      end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input bit s, input logic [15:0] e);
    int n = 0;
    in_valid8 = 1'b1; a8 = a; b8 = b; s8 = s;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      if (n >= 100) begin
        chk("w8_accept_timeout", 32'(in_ready8), 32'd1);
        break;
      end
      @(posedge clk); #1; n++;
    end
    exp8_q.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
  endtask

  task automatic w5_seq();
    logic [4:0] va[6] = '{5'h10, 5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h00};
    logic [4:0] vb[6] = '{5'h10, 5'h1F, 5'h1F, 5'h01, 5'h13, 5'h13};
    bit         vs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [9:0] ve[6] = '{10'h100, 10'h3C1, 10'h001, 10'h3FF, 10'h000, 10'h000};
    int n;
    @(negedge clk);
    chk("w5_rst_out_valid", 32'(out_valid5), 32'd0);
    chk("w5_rst_in_ready", 32'(in_ready5), 32'd1);
    chk("w5_rst_product", 32'(product5), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      accept5(va[i], vb[i], vs[i], 1'b1, ve[i]);
      wait_valid5(n);
      chk("w5_latency", 32'(n), 32'd5);
      @(posedge clk); #1;
    end
    // Stall the consumer for 7 cycles, then restart back-to-back.
    out_ready5 = 1'b0;
    accept5(5'd6, 5'd7, 1'b0, 1'b1, 10'd42);
    wait_valid5(n);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("w5_stall_valid", 32'(out_valid5), 32'd1);
      chk("w5_stall_product", 32'(product5), 32'd42);
      chk("w5_stall_in_ready", 32'(in_ready5), 32'd0);
    end
    @(posedge clk); #1;
    out_ready5 = 1'b1;
    in_valid5 = 1'b1; a5 = 5'd3; b5 = 5'h1E; s5 = 1'b1;
    @(negedge clk);
    chk("w5_b2b_in_ready", 32'(in_ready5), 32'd1);
    exp5_q.push_back(10'h3FA);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    wait_valid5(n);
    chk("w5_b2b_latency", 32'(n), 32'd5);
    @(posedge clk); #1;
    // Reset while row==2 of a run; that transaction must never surface.
    accept5(5'd7, 5'd9, 1'b0, 1'b0, 10'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst5_n = 1'b0;
    @(posedge clk); #1;
    rst5_n = 1'b1;
    @(negedge clk);
    chk("w5_midrst_out_valid", 32'(out_valid5), 32'd0);
    chk("w5_midrst_in_ready", 32'(in_ready5), 32'd1);
    chk("w5_midrst_product", 32'(product5), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    accept5(5'd2, 5'd3, 1'b0, 1'b1, 10'd6);
    wait_valid5(n);
    chk("w5_post_rst_latency", 32'(n), 32'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w5_queue_drained", 32'(exp5_q.size()), 32'd0);
  endtask

  task automatic w8_seq();
    logic [7:0] a, b;
    bit s;
    int n;
    drive_ready8 = 1'b1;
    @(posedge clk); #1;
    accept8(8'h80, 8'h80, 1'b1, 16'h4000);
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      accept8(a, b, s, ref_mul(32'(a), 32'(b), s, 8));
      repeat ($urandom_range(1)) @(posedge clk);
      #0;
    end
    drive_ready8 = 1'b0;
    n = 0;
    while (exp8_q.size() != 0 && n < 500) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("w8_queue_drained", 32'(exp8_q.size()), 32'd0);
  endtask

  initial begin
    rst5_n = 1'b0; rst8_n = 1'b0;
    in_valid5 = 1'b0; a5 = '0; b5 = '0; s5 = 1'b0; out_ready5 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    pv8 = 1'b0; pr8 = 1'b1; drive_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst5_n = 1'b1; rst8_n = 1'b1;
    fork
      w5_seq();
      w8_seq();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog_timeout got=running expected=finished at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
